// File: rtl/key_event.sv
// key_event: turns a debounced button level into one-cycle press, release,
// click, long-press and auto-repeat pulses, plus a registered "held" level.
// Every output is registered, so each event appears exactly one clock after
// the input edge that caused it.
module key_event #(
    parameter int LONG_CNT   = 25_000_000,
    parameter int REPEAT_CNT = 5_000_000,
    parameter bit REPEAT_EN  = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_held
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Terminal counts; the counter is cleared on reaching them, so it never wraps.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_press;
    logic             w_release;
    logic             w_click;
    logic             w_longPress;
    logic             w_repeat;

    // Next-state, counter and event decode; a falling input always wins
    // over a long-press or repeat terminal count on the same edge.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_longPress = 1'b0;
        w_repeat    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_in) begin
                    w_press     = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = PRESS;
                end
            end

            PRESS: begin
                if (!i_in) begin
                    w_release   = 1'b1;
                    w_click     = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_longPress = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = HOLD;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end

            HOLD: begin
                if (!i_in) begin
                    w_release   = 1'b1;
                    w_cntNext   = '0;
                    w_stateNext = IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat    = REPEAT_EN;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_cntNext   = '0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything at once
    // and deliberately produces no release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            o_press      <= 1'b0;
            o_release    <= 1'b0;
            o_click      <= 1'b0;
            o_long_press <= 1'b0;
            o_repeat     <= 1'b0;
            o_held       <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            o_press      <= w_press;
            o_release    <= w_release;
            o_click      <= w_click;
            o_long_press <= w_longPress;
            o_repeat     <= w_repeat;
            o_held       <= (w_stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: drives two key_event instances (auto-repeat enabled and
// disabled) from one button level and checks them every cycle against an
// event-level model of the button, plus hand-computed event tallies.
module tb_key_event;

    localparam int LONG_CNT   = 8;
    localparam int REPEAT_CNT = 3;

    logic clk;
    logic rst_n;
    logic tbIn;

    logic aPress, aRelease, aClick, aLong, aRepeat, aHeld;
    logic bPress, bRelease, bClick, bLong, bRepeat, bHeld;

    logic [5:0] dutOut [2];

    // Behavioural model state, one slot per instance (0 = repeat on, 1 = off)
    bit         mPressed [2];
    bit         mLongDone [2];
    int         mAge [2];
    logic [5:0] mOut [2];

    // Event tallies of what each DUT emitted: press, release, click, long, repeat
    int tally [2][5];

    int testsRun;
    int testsFailed;

    key_event #(
        .LONG_CNT  (LONG_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .REPEAT_EN (1'b1),
        .CNT_W     (8)
    ) dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in        (tbIn),
        .o_press     (aPress),
        .o_release   (aRelease),
        .o_click     (aClick),
        .o_long_press(aLong),
        .o_repeat    (aRepeat),
        .o_held      (aHeld)
    );

    key_event #(
        .LONG_CNT  (LONG_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .REPEAT_EN (1'b0),
        .CNT_W     (8)
    ) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in        (tbIn),
        .o_press     (bPress),
        .o_release   (bRelease),
        .o_click     (bClick),
        .o_long_press(bLong),
        .o_repeat    (bRepeat),
        .o_held      (bHeld)
    );

    assign dutOut[0] = {aPress, aRelease, aClick, aLong, aRepeat, aHeld};
    assign dutOut[1] = {bPress, bRelease, bClick, bLong, bRepeat, bHeld};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the test and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold the button level for n rising edges, returning just after the last edge
    task automatic applyStimulus(input logic v, input int n);
        tbIn = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetTallies();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 5; j++)
                tally[i][j] = 0;
    endtask

    // Button model: tracks how many held edges have elapsed since the press
    // and derives every event from that age, not from a copy of the FSM.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mPressed[i]  = 1'b0;
                mLongDone[i] = 1'b0;
                mAge[i]      = 0;
                mOut[i]      = '0;
            end else begin
                logic pr, rl, ck, lp, rp;
                pr = 0; rl = 0; ck = 0; lp = 0; rp = 0;
                if (!mPressed[i]) begin
                    if (tbIn) begin
                        pr = 1;
                        mPressed[i]  = 1'b1;
                        mLongDone[i] = 1'b0;
                        mAge[i]      = 0;
                    end
                end else if (!tbIn) begin
                    rl = 1;
                    ck = !mLongDone[i];
                    mPressed[i] = 1'b0;
                end else begin
                    mAge[i]++;
                    if (!mLongDone[i] && mAge[i] == LONG_CNT) begin
                        lp = 1;
                        mLongDone[i] = 1'b1;
                    end else if (mLongDone[i] && i == 0 &&
                                 ((mAge[i] - LONG_CNT) % REPEAT_CNT) == 0) begin
                        rp = 1;
                    end
                end
                mOut[i] = {pr, rl, ck, lp, rp, mPressed[i]};
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        checkOutput("dutA_outputs", 32'(dutOut[0]), 32'(mOut[0]));
        checkOutput("dutB_outputs", 32'(dutOut[1]), 32'(mOut[1]));
        for (int i = 0; i < 2; i++) begin
            if (dutOut[i][5]) tally[i][0]++;
            if (dutOut[i][4]) tally[i][1]++;
            if (dutOut[i][3]) tally[i][2]++;
            if (dutOut[i][2]) tally[i][3]++;
            if (dutOut[i][1]) tally[i][4]++;
        end
    end

    initial begin
        logic v;
        testsRun    = 0;
        testsFailed = 0;
        resetTallies();

        // Reset held with the button down: outputs stay clear
        rst_n = 1'b0;
        tbIn  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs_A", 32'(dutOut[0]), 32'h0);
        checkOutput("reset_outputs_B", 32'(dutOut[1]), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1);
        checkOutput("reset_first_press", 32'(aPress), 32'h1);
        checkOutput("reset_first_held", 32'(aHeld), 32'h1);
        applyStimulus(1'b0, 3);

        // Short tap of five edges
        resetTallies();
        applyStimulus(1'b1, 5);
        applyStimulus(1'b0, 1);
        checkOutput("tap_release", 32'(aRelease), 32'h1);
        checkOutput("tap_click", 32'(aClick), 32'h1);
        applyStimulus(1'b0, 3);
        checkOutput("tap_press_count", 32'(tally[0][0]), 32'd1);
        checkOutput("tap_long_count", 32'(tally[0][3]), 32'd0);

        // Long hold of sixteen edges: long at k+8, repeats at k+11 and k+14
        resetTallies();
        applyStimulus(1'b1, 16);
        applyStimulus(1'b0, 3);
        checkOutput("hold_long_count", 32'(tally[0][3]), 32'd1);
        checkOutput("hold_repeat_count", 32'(tally[0][4]), 32'd2);
        checkOutput("hold_release_count", 32'(tally[0][1]), 32'd1);
        checkOutput("hold_click_count", 32'(tally[0][2]), 32'd0);

        // Release on the long-press terminal edge: click wins, no long
        resetTallies();
        applyStimulus(1'b1, 8);
        applyStimulus(1'b0, 3);
        checkOutput("tie_long_count", 32'(tally[0][3]), 32'd0);
        checkOutput("tie_click_count", 32'(tally[0][2]), 32'd1);

        // Twenty-edge hold: repeat-disabled instance never repeats
        resetTallies();
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 3);
        checkOutput("norep_long_count", 32'(tally[1][3]), 32'd1);
        checkOutput("norep_repeat_count", 32'(tally[1][4]), 32'd0);
        checkOutput("norep_release_count", 32'(tally[1][1]), 32'd1);
        checkOutput("rep20_repeat_count", 32'(tally[0][4]), 32'd3);

        // Back-to-back single-cycle taps
        resetTallies();
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 2);
        checkOutput("b2b_press_count", 32'(tally[0][0]), 32'd2);
        checkOutput("b2b_click_count", 32'(tally[0][2]), 32'd2);

        // Asynchronous reset while in HOLD: immediate clear, no release
        resetTallies();
        applyStimulus(1'b1, 12);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midhold_reset_A", 32'(dutOut[0]), 32'h0);
        checkOutput("midhold_reset_B", 32'(dutOut[1]), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1);
        checkOutput("midhold_repress", 32'(aPress), 32'h1);
        applyStimulus(1'b0, 3);
        checkOutput("midhold_release_count", 32'(tally[0][1]), 32'd1);

        // Randomized runs of alternating levels with occasional resets
        v = 1'b0;
        for (int r = 0; r < 250; r++) begin
            v = ~v;
            applyStimulus(v, $urandom_range(1, 20));
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        applyStimulus(1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
